// File: rtl/clip_ctrl_pkg.sv
// Shared types and default sizing for the multi-clip record/playback sequencer.
package clip_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRecord = 2'b01,
    StPlay   = 2'b10
  } state_t;

  localparam int unsigned DefNumClips  = 8;
  localparam int unsigned DefClipWords = 16384;
  localparam int unsigned DefAddrW     = 17;

endpackage

// File: rtl/clip_len_table.sv
// Per-clip recorded-length store; a slot counts as valid whenever its length is nonzero.
module clip_len_table #(
  parameter int unsigned NUM_CLIPS = 8,
  parameter int unsigned LEN_W     = 15,
  parameter int unsigned CLIP_W    = $clog2(NUM_CLIPS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 we,
  input  logic [CLIP_W-1:0]    idx,
  input  logic [LEN_W-1:0]     wdata,
  output logic [LEN_W-1:0]     rdata,
  output logic [NUM_CLIPS-1:0] clip_valid
);

  logic [LEN_W-1:0] len_q [NUM_CLIPS];
  logic [LEN_W-1:0] len_d [NUM_CLIPS];

  // Single write port: only the addressed slot may change.
  always_comb begin
    len_d = len_q;
    if (we) len_d[idx] = wdata;
  end

  // Length registers, cleared by synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) len_q <= '{default: '0};
    else       len_q <= len_d;
  end

  // Read port and per-slot valid flags.
  always_comb begin
    rdata = len_q[idx];
    for (int i = 0; i < int'(NUM_CLIPS); i++) clip_valid[i] = |len_q[i];
  end

endmodule

// File: rtl/clip_controller.sv
// Multi-clip record/playback sequencer: FSM, per-sample offset counter and memory strobes.
module clip_controller
  import clip_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CLIPS  = DefNumClips,
  parameter int unsigned CLIP_WORDS = DefClipWords,
  parameter int unsigned ADDR_W     = DefAddrW,
  localparam int unsigned CLIP_W    = $clog2(NUM_CLIPS),
  localparam int unsigned OFF_W     = $clog2(CLIP_WORDS),
  localparam int unsigned LEN_W     = OFF_W + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 action,
  input  logic                 play_or_record,
  input  logic [CLIP_W-1:0]    clip_sel,
  input  logic                 stop,
  input  logic                 sample_tick,
  output logic                 enable_des,
  output logic                 enable_ser,
  output logic                 enable_timer,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic                 done,
  output logic                 err,
  output logic [NUM_CLIPS-1:0] clip_valid
);

  localparam logic [OFF_W-1:0] LastOff = OFF_W'(CLIP_WORDS - 1);

  state_t              state_q, state_d;
  logic [OFF_W-1:0]    offset_q, offset_d;
  logic [CLIP_W-1:0]   cur_clip_q, cur_clip_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                len_we;
  logic [LEN_W-1:0]    len_wdata;
  logic [LEN_W-1:0]    rd_len;
  logic [CLIP_W-1:0]   tbl_idx;

  // In IDLE the table is addressed by the request; otherwise by the active clip.
  assign tbl_idx = (state_q == StIdle) ? clip_sel : cur_clip_q;

  clip_len_table #(
    .NUM_CLIPS (NUM_CLIPS),
    .LEN_W     (LEN_W),
    .CLIP_W    (CLIP_W)
  ) u_len_table (
    .clock      (clock),
    .reset      (reset),
    .we         (len_we),
    .idx        (tbl_idx),
    .wdata      (len_wdata),
    .rdata      (rd_len),
    .clip_valid (clip_valid)
  );

  // State, offset, clip and pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      offset_q   <= '0;
      cur_clip_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      cur_clip_q <= cur_clip_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state, offset advance and length-table updates.
  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    cur_clip_d = cur_clip_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    len_we     = 1'b0;
    len_wdata  = '0;
    unique case (state_q)
      StIdle: begin
        if (action) begin
          if (play_or_record) begin
            // Zeroing the length on entry drops the slot's valid flag while recording.
            cur_clip_d = clip_sel;
            offset_d   = '0;
            len_we     = 1'b1;
            state_d    = StRecord;
          end else if (rd_len != '0) begin
            cur_clip_d = clip_sel;
            offset_d   = '0;
            state_d    = StPlay;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRecord: begin
        if (sample_tick) offset_d = offset_q + OFF_W'(1);
        if (sample_tick && (offset_q == LastOff)) begin
          len_we    = 1'b1;
          len_wdata = LEN_W'(CLIP_WORDS);
          done_d    = 1'b1;
          state_d   = StIdle;
        end else if (stop) begin
          len_we    = 1'b1;
          len_wdata = {1'b0, offset_q} + LEN_W'(sample_tick);
          done_d    = 1'b1;
          state_d   = StIdle;
        end
      end
      StPlay: begin
        if (sample_tick) offset_d = offset_q + OFF_W'(1);
        if ((sample_tick && (({1'b0, offset_q} + LEN_W'(1)) == rd_len)) || stop) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Enables and zero-latency strobes decoded from the current state.
  always_comb begin
    enable_des   = (state_q == StRecord);
    enable_ser   = (state_q == StPlay);
    enable_timer = enable_des | enable_ser;
    mem_we       = enable_des & sample_tick;
    mem_re       = enable_ser & sample_tick;
    mem_addr     = ADDR_W'({cur_clip_q, offset_q});
    done         = done_q;
    err          = err_q;
  end

endmodule

// File: tb/tb_clip_controller.sv
// Directed bench for clip_controller: default geometry plus a 4-word-per-clip instance.
module tb_clip_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       action = 1'b0;
  logic       play_or_record = 1'b0;
  logic [2:0] clip_sel = '0;
  logic       stop = 1'b0;
  logic       sample_tick = 1'b0;

  logic        enable_des, enable_ser, enable_timer, mem_we, mem_re, done, err;
  logic [16:0] mem_addr;
  logic [7:0]  clip_valid;

  logic        s_enable_des, s_enable_ser, s_enable_timer, s_mem_we, s_mem_re, s_done, s_err;
  logic [4:0]  s_mem_addr;
  logic [7:0]  s_clip_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  clip_controller u_dut (
    .clock          (clock),
    .reset          (reset),
    .action         (action),
    .play_or_record (play_or_record),
    .clip_sel       (clip_sel),
    .stop           (stop),
    .sample_tick    (sample_tick),
    .enable_des     (enable_des),
    .enable_ser     (enable_ser),
    .enable_timer   (enable_timer),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_re         (mem_re),
    .done           (done),
    .err            (err),
    .clip_valid     (clip_valid)
  );

  clip_controller #(
    .NUM_CLIPS  (8),
    .CLIP_WORDS (4),
    .ADDR_W     (5)
  ) u_small (
    .clock          (clock),
    .reset          (reset),
    .action         (action),
    .play_or_record (play_or_record),
    .clip_sel       (clip_sel),
    .stop           (stop),
    .sample_tick    (sample_tick),
    .enable_des     (s_enable_des),
    .enable_ser     (s_enable_ser),
    .enable_timer   (s_enable_timer),
    .mem_addr       (s_mem_addr),
    .mem_we         (s_mem_we),
    .mem_re         (s_mem_re),
    .done           (s_done),
    .err            (s_err),
    .clip_valid     (s_clip_valid)
  );

  // Apply inputs on the falling edge; sample 1 time unit later, well away from the rising edge.
  task automatic drive(input logic a, input logic por, input logic [2:0] sel,
                       input logic st, input logic tk);
    @(negedge clock);
    action = a; play_or_record = por; clip_sel = sel; stop = st; sample_tick = tk;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({enable_des, enable_ser, enable_timer, mem_we, mem_re, done, err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 0000000",
               {enable_des, enable_ser, enable_timer, mem_we, mem_re, done, err});
    end
    n_checks++;
    if (mem_addr !== 17'h0) begin
      n_fail++; $display("FAIL reset_addr: got %h want 00000", mem_addr);
    end
    n_checks++;
    if (clip_valid !== 8'h00) begin
      n_fail++; $display("FAIL reset_valid: got %h want 00", clip_valid);
    end
  endtask

  task automatic test_play_empty();
    drive(1, 0, 3, 0, 0);
    drive(0, 0, 0, 0, 0);
    n_checks++;
    if ({err, enable_ser, enable_timer} !== 3'b100) begin
      n_fail++; $display("FAIL empty_err: got err/ser/tmr %b want 100", {err, enable_ser, enable_timer});
    end
    drive(0, 0, 0, 0, 0);
    n_checks++;
    if (err !== 1'b0 || clip_valid !== 8'h00) begin
      n_fail++; $display("FAIL empty_pulse: got err %b valid %h want 0 00", err, clip_valid);
    end
  endtask

  task automatic test_record_stop();
    drive(1, 1, 2, 0, 0);
    drive(0, 0, 0, 0, 0);
    n_checks++;
    if ({enable_des, enable_ser, enable_timer} !== 3'b101 || mem_addr !== 17'h08000) begin
      n_fail++;
      $display("FAIL rec_entry: got des/ser/tmr %b addr %h want 101 08000",
               {enable_des, enable_ser, enable_timer}, mem_addr);
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 1);
      n_checks++;
      if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 17'h08000 + 17'(i)) begin
        n_fail++;
        $display("FAIL rec_write%0d: got we %b re %b addr %h want 1 0 %h",
                 i, mem_we, mem_re, mem_addr, 17'h08000 + 17'(i));
      end
      drive(0, 0, 0, 0, 0);
      n_checks++;
      if (mem_we !== 1'b0) begin
        n_fail++; $display("FAIL rec_gap%0d: got we %b want 0", i, mem_we);
      end
    end
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    n_checks++;
    if (done !== 1'b1 || enable_des !== 1'b0 || clip_valid !== 8'h04) begin
      n_fail++;
      $display("FAIL rec_done: got done %b des %b valid %h want 1 0 04", done, enable_des, clip_valid);
    end
    drive(0, 0, 0, 0, 0);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL rec_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_play();
    drive(1, 0, 2, 0, 0);
    drive(0, 0, 0, 0, 0);
    n_checks++;
    if (enable_ser !== 1'b1 || err !== 1'b0) begin
      n_fail++; $display("FAIL play_entry: got ser %b err %b want 1 0", enable_ser, err);
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 1);
      n_checks++;
      if (mem_re !== 1'b1 || mem_we !== 1'b0 || done !== 1'b0 || mem_addr !== 17'h08000 + 17'(i)) begin
        n_fail++;
        $display("FAIL play_read%0d: got re %b we %b done %b addr %h want 1 0 0 %h",
                 i, mem_re, mem_we, done, mem_addr, 17'h08000 + 17'(i));
      end
      drive(0, 0, 0, 0, 0);
    end
    n_checks++;
    if (done !== 1'b1 || enable_ser !== 1'b0 || clip_valid !== 8'h04) begin
      n_fail++;
      $display("FAIL play_done: got done %b ser %b valid %h want 1 0 04", done, enable_ser, clip_valid);
    end
    drive(0, 0, 0, 0, 1);
    n_checks++;
    if (mem_re !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL play_extra: got re %b done %b want 0 0", mem_re, done);
    end
  endtask

  task automatic test_small_config();
    do_reset();
    drive(1, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1);
      n_checks++;
      if (s_mem_we !== 1'b1 || s_mem_addr !== 5'd4 + 5'(i)) begin
        n_fail++;
        $display("FAIL small_write%0d: got we %b addr %h want 1 %h", i, s_mem_we, s_mem_addr, 5'd4 + 5'(i));
      end
      drive(0, 0, 0, 0, 0);
    end
    n_checks++;
    if (s_done !== 1'b1 || s_enable_des !== 1'b0 || s_clip_valid !== 8'h02) begin
      n_fail++;
      $display("FAIL small_auto_done: got done %b des %b valid %h want 1 0 02",
               s_done, s_enable_des, s_clip_valid);
    end
    // Play back with ticks on consecutive cycles; length 4 must end after the 4th read.
    drive(1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1);
      n_checks++;
      if (s_mem_re !== 1'b1 || s_done !== 1'b0 || s_mem_addr !== 5'd4 + 5'(i)) begin
        n_fail++;
        $display("FAIL small_read%0d: got re %b done %b addr %h want 1 0 %h",
                 i, s_mem_re, s_done, s_mem_addr, 5'd4 + 5'(i));
      end
    end
    drive(0, 0, 0, 0, 1);
    n_checks++;
    if (s_done !== 1'b1 || s_mem_re !== 1'b0 || s_enable_ser !== 1'b0) begin
      n_fail++;
      $display("FAIL small_play_done: got done %b re %b ser %b want 1 0 0", s_done, s_mem_re, s_enable_ser);
    end
  endtask

  task automatic test_stop_with_tick();
    do_reset();
    drive(1, 1, 5, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1);
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 17'h14002) begin
      n_fail++; $display("FAIL stoptick_write: got we %b addr %h want 1 14002", mem_we, mem_addr);
    end
    drive(0, 0, 0, 0, 0);
    n_checks++;
    if (done !== 1'b1 || clip_valid !== 8'h20) begin
      n_fail++; $display("FAIL stoptick_done: got done %b valid %h want 1 20", done, clip_valid);
    end
    // Length 3 must be recorded: playback ends exactly after the third read.
    drive(1, 0, 5, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0);
      n_checks++;
      if (done !== 1'b0 || enable_ser !== 1'b1) begin
        n_fail++; $display("FAIL stoptick_play%0d: got done %b ser %b want 0 1", i, done, enable_ser);
      end
      drive(0, 0, 0, 0, 1);
    end
    drive(0, 0, 0, 0, 0);
    n_checks++;
    if (done !== 1'b1 || enable_ser !== 1'b0) begin
      n_fail++; $display("FAIL stoptick_len: got done %b ser %b want 1 0", done, enable_ser);
    end
  endtask

  task automatic test_reset_mid_play();
    drive(1, 0, 5, 0, 0);
    drive(0, 0, 0, 0, 1);
    reset = 1'b1;
    drive(0, 0, 0, 0, 1);
    n_checks++;
    if ({enable_des, enable_ser, enable_timer, mem_we, mem_re, done, err} !== 7'b0 ||
        mem_addr !== 17'h0 || clip_valid !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_outs: got ctl %b addr %h valid %h want 0000000 00000 00",
               {enable_des, enable_ser, enable_timer, mem_we, mem_re, done, err}, mem_addr, clip_valid);
    end
    reset = 1'b0;
    drive(1, 1, 6, 0, 0);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL midreset_nodone: got %b want 0", done);
    end
    drive(0, 0, 0, 0, 0);
    n_checks++;
    if (enable_des !== 1'b1 || done !== 1'b0 || mem_addr !== 17'h18000) begin
      n_fail++;
      $display("FAIL midreset_action: got des %b done %b addr %h want 1 0 18000", enable_des, done, mem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_play_empty();
    test_record_stop();
    test_play();
    test_small_config();
    test_stop_with_tick();
    test_reset_mid_play();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
